// File: rtl/time_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_pkg
// Description : Shared constants, digit widths and BCD helpers for the
//               time-of-day core and its BCD sub-counter.
// Revision    : 1.0 - initial release
// ============================================================================
package clock_pkg;

  // Count limits
  localparam int unsigned SEC_MAX  = 59;
  localparam int unsigned MIN_MAX  = 59;
  localparam int unsigned HR24_MAX = 23;
  localparam int unsigned HR12_MAX = 12;
  localparam int unsigned HR12_MIN = 1;

  // BCD digit widths
  localparam int ONES_W     = 4;
  localparam int HR_TENS_W  = 2;
  localparam int MIN_TENS_W = 3;
  localparam int SEC_TENS_W = 3;

  typedef logic [ONES_W-1:0] bcd_digit_t;

  // Units digit of a decimal constant, for building digit-wise compare values
  function automatic bcd_digit_t ones_of(input int unsigned val);
    return bcd_digit_t'(val % 10);
  endfunction

endpackage
`default_nettype wire

// File: rtl/time_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : time_counter_if
// Description : Bundles the time-of-day core's control inputs and BCD time
//               outputs.
//   master : drives tick_in/set_en/inc_hr/inc_min, reads the time digits
//   slave  : the time_counter core
//   tick_in  1 Hz square wave (asynchronous)
//   set_en   set-mode level
//   inc_hr   hour increment pulse (set mode only)
//   inc_min  minute increment pulse (set mode only)
//   hr_tens/hr_ones/min_tens/min_ones/sec_tens/sec_ones  BCD digits
//   pm       afternoon flag (12-hour build only)
//   sec_tick one-cycle pulse on each seconds advance
// Revision    : 1.0 - initial release
// ============================================================================
interface time_counter_if;
  logic                                tick_in;
  logic                                set_en;
  logic                                inc_hr;
  logic                                inc_min;
  logic [clock_pkg::HR_TENS_W-1:0]     hr_tens;
  logic [clock_pkg::ONES_W-1:0]        hr_ones;
  logic [clock_pkg::MIN_TENS_W-1:0]    min_tens;
  logic [clock_pkg::ONES_W-1:0]        min_ones;
  logic [clock_pkg::SEC_TENS_W-1:0]    sec_tens;
  logic [clock_pkg::ONES_W-1:0]        sec_ones;
  logic                                pm;
  logic                                sec_tick;

  modport master (
    output tick_in, set_en, inc_hr, inc_min,
    input  hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones, pm, sec_tick
  );

  modport slave (
    input  tick_in, set_en, inc_hr, inc_min,
    output hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones, pm, sec_tick
  );
endinterface
`default_nettype wire

// File: rtl/time_counter_bcd.sv
`default_nettype none
// ============================================================================
// Module      : bcd_mod_counter
// Description : Two-digit BCD counter wrapping from MAX back to MIN.
//   clkin  system clock
//   rst    asynchronous active-high reset, loads RST_VAL
//   clr    synchronous load of MIN (takes priority over inc)
//   inc    advance by one
//   tens   tens digit (TENS_W bits)
//   ones   units digit
//   carry  combinational: inc accepted while at MAX (wrap this cycle)
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int          TENS_W  = 3,
  parameter int unsigned MAX     = 59,
  parameter int unsigned MIN     = 0,
  parameter int unsigned RST_VAL = 0
) (
  input  wire logic              clkin,
  input  wire logic              rst,
  input  wire logic              clr,
  input  wire logic              inc,
  output      logic [TENS_W-1:0] tens,
  output      bcd_digit_t        ones,
  output      logic              carry
);

  localparam logic [TENS_W-1:0] MAX_T = TENS_W'(MAX / 10);
  localparam bcd_digit_t        MAX_O = ones_of(MAX);
  localparam logic [TENS_W-1:0] MIN_T = TENS_W'(MIN / 10);
  localparam bcd_digit_t        MIN_O = ones_of(MIN);
  localparam logic [TENS_W-1:0] RST_T = TENS_W'(RST_VAL / 10);
  localparam bcd_digit_t        RST_O = ones_of(RST_VAL);

  logic at_max;

  assign at_max = (tens == MAX_T) && (ones == MAX_O);
  // A cleared counter never wraps, so it never carries.
  assign carry  = inc && !clr && at_max;

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      tens <= RST_T;
      ones <= RST_O;
    end else if (clr) begin
      tens <= MIN_T;
      ones <= MIN_O;
    end else if (inc) begin
      if (at_max) begin
        tens <= MIN_T;
        ones <= MIN_O;
      end else if (ones == 4'd9) begin
        // Digit-wise increment keeps both digits legal BCD throughout.
        tens <= tens + TENS_W'(1);
        ones <= '0;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/time_counter.sv
`default_nettype none
// ============================================================================
// Module      : time_counter
// Description : Time-of-day core. Synchronises the 1 Hz tick, detects its
//               rising edge and advances a BCD hh:mm:ss count; set mode
//               allows manual hour/minute adjustment.
//   clkin  system clock
//   rst    asynchronous active-high reset
//   bus    time_counter_if.slave (control inputs, BCD time outputs)
//   H24          1 = 00-23 hours, 0 = 12,01-11 hours with pm flag
//   SYNC_STAGES  synchroniser depth on tick_in (values below 2 use 2)
// Revision    : 1.0 - initial release
// ============================================================================
module time_counter
  import clock_pkg::*;
#(
  parameter bit          H24         = 1'b1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input wire logic        clkin,
  input wire logic        rst,
  time_counter_if.slave   bus
);

  localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [SYNC_N-1:0]         sync_q;
  logic                      prev_q;
  logic                      adv;
  logic                      count_adv;
  logic                      sec_carry;
  logic                      min_inc;
  logic                      min_carry;
  logic                      hr_inc;
  logic                      sec_tick_q;
  logic [HR_TENS_W-1:0]      hr_tens_q;
  bcd_digit_t                hr_ones_q;
  logic                      pm_q;
  logic [MIN_TENS_W-1:0]     min_tens_q;
  bcd_digit_t                min_ones_q;
  logic [SEC_TENS_W-1:0]     sec_tens_q;
  bcd_digit_t                sec_ones_q;

  // tick_in synchroniser plus one history flop for rising-edge detection
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_N-2:0], bus.tick_in};
      prev_q <= sync_q[SYNC_N-1];
    end
  end

  assign adv       = sync_q[SYNC_N-1] && !prev_q;
  // An advance arriving while in set mode is dropped, not deferred.
  assign count_adv = adv && !bus.set_en;

  // In set mode the increment pulses drive minutes/hours directly and the
  // seconds-to-minutes-to-hours carry chain is cut.
  assign min_inc = bus.set_en ? bus.inc_min : sec_carry;
  assign hr_inc  = bus.set_en ? bus.inc_hr  : min_carry;

  bcd_mod_counter #(
    .TENS_W  (SEC_TENS_W),
    .MAX     (SEC_MAX),
    .MIN     (0),
    .RST_VAL (0)
  ) u_sec (
    .clkin (clkin),
    .rst   (rst),
    .clr   (bus.set_en),
    .inc   (count_adv),
    .tens  (sec_tens_q),
    .ones  (sec_ones_q),
    .carry (sec_carry)
  );

  bcd_mod_counter #(
    .TENS_W  (MIN_TENS_W),
    .MAX     (MIN_MAX),
    .MIN     (0),
    .RST_VAL (0)
  ) u_min (
    .clkin (clkin),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (min_inc),
    .tens  (min_tens_q),
    .ones  (min_ones_q),
    .carry (min_carry)
  );

  generate
    if (H24) begin : g_h24
      localparam logic [HR_TENS_W-1:0] MAX_T = HR_TENS_W'(HR24_MAX / 10);
      localparam bcd_digit_t           MAX_O = ones_of(HR24_MAX);

      always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
          hr_tens_q <= '0;
          hr_ones_q <= '0;
        end else if (hr_inc) begin
          if ((hr_tens_q == MAX_T) && (hr_ones_q == MAX_O)) begin
            hr_tens_q <= '0;
            hr_ones_q <= '0;
          end else if (hr_ones_q == 4'd9) begin
            hr_tens_q <= hr_tens_q + 2'd1;
            hr_ones_q <= '0;
          end else begin
            hr_ones_q <= hr_ones_q + 4'd1;
          end
        end
      end

      assign pm_q = 1'b0;
    end else begin : g_h12
      localparam logic [HR_TENS_W-1:0] MAX_T = HR_TENS_W'(HR12_MAX / 10);
      localparam bcd_digit_t           MAX_O = ones_of(HR12_MAX);
      localparam logic [HR_TENS_W-1:0] MIN_T = HR_TENS_W'(HR12_MIN / 10);
      localparam bcd_digit_t           MIN_O = ones_of(HR12_MIN);
      localparam logic [HR_TENS_W-1:0] PRE_T = HR_TENS_W'((HR12_MAX - 1) / 10);
      localparam bcd_digit_t           PRE_O = ones_of(HR12_MAX - 1);

      // Count order is 12, 01 .. 11; pm flips on the 11 -> 12 step.
      always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
          hr_tens_q <= MAX_T;
          hr_ones_q <= MAX_O;
          pm_q      <= 1'b0;
        end else if (hr_inc) begin
          if ((hr_tens_q == MAX_T) && (hr_ones_q == MAX_O)) begin
            hr_tens_q <= MIN_T;
            hr_ones_q <= MIN_O;
          end else if ((hr_tens_q == PRE_T) && (hr_ones_q == PRE_O)) begin
            hr_tens_q <= MAX_T;
            hr_ones_q <= MAX_O;
            pm_q      <= !pm_q;
          end else if (hr_ones_q == 4'd9) begin
            hr_tens_q <= hr_tens_q + 2'd1;
            hr_ones_q <= '0;
          end else begin
            hr_ones_q <= hr_ones_q + 4'd1;
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      sec_tick_q <= 1'b0;
    end else begin
      sec_tick_q <= count_adv;
    end
  end

  assign bus.hr_tens  = hr_tens_q;
  assign bus.hr_ones  = hr_ones_q;
  assign bus.min_tens = min_tens_q;
  assign bus.min_ones = min_ones_q;
  assign bus.sec_tens = sec_tens_q;
  assign bus.sec_ones = sec_ones_q;
  assign bus.pm       = pm_q;
  assign bus.sec_tick = sec_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_time_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_time_counter
// Description : Self-checking bench for time_counter. Runs a 24-hour and a
//               12-hour instance side by side on identical stimulus and
//               compares both against a seconds/minutes/hours model every
//               cycle, plus literal checkpoints from directed scenarios and
//               a randomised phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_time_counter;

  localparam int SYNC = 2;

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic tick    = 1'b0;
  logic set_en  = 1'b0;
  logic inc_hr  = 1'b0;
  logic inc_min = 1'b0;

  int errors = 0;
  int checks = 0;

  // Model: plain hour (0-23), minute and second integers.
  int mh = 0, mm = 0, ms = 0;
  int pend[$];
  int cyc = 0;
  bit prev_t = 1'b0;
  bit exp_tick = 1'b0;
  bit adv_m;
  int model_ticks = 0;
  int dut_ticks = 0;

  time_counter_if bus24 ();
  time_counter_if bus12 ();

  assign bus24.tick_in = tick;
  assign bus24.set_en  = set_en;
  assign bus24.inc_hr  = inc_hr;
  assign bus24.inc_min = inc_min;
  assign bus12.tick_in = tick;
  assign bus12.set_en  = set_en;
  assign bus12.inc_hr  = inc_hr;
  assign bus12.inc_min = inc_min;

  time_counter #(.H24(1'b1), .SYNC_STAGES(SYNC)) dut24 (
    .clkin (clk),
    .rst   (rst),
    .bus   (bus24)
  );

  time_counter #(.H24(1'b0), .SYNC_STAGES(SYNC)) dut12 (
    .clkin (clk),
    .rst   (rst),
    .bus   (bus12)
  );

  always #5 clk = ~clk;

  // Time digits packed one per nibble so an illegal BCD digit stays visible.
  logic [23:0] a24, a12;
  assign a24 = {2'b0, bus24.hr_tens, bus24.hr_ones, 1'b0, bus24.min_tens, bus24.min_ones,
                1'b0, bus24.sec_tens, bus24.sec_ones};
  assign a12 = {2'b0, bus12.hr_tens, bus12.hr_ones, 1'b0, bus12.min_tens, bus12.min_ones,
                1'b0, bus12.sec_tens, bus12.sec_ones};

  function automatic int bcd6(input int h, input int m, input int s);
    return ((h / 10) << 20) | ((h % 10) << 16) | ((m / 10) << 12) |
           ((m % 10) << 8) | ((s / 10) << 4) | (s % 10);
  endfunction

  function automatic int h12_of(input int h);
    return (h % 12 == 0) ? 12 : (h % 12);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model, updated at each active edge from the sampled inputs.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mh = 0; mm = 0; ms = 0;
      pend.delete();
      prev_t = 1'b0;
      exp_tick = 1'b0;
      cyc = 0;
    end else begin
      cyc++;
      adv_m = 1'b0;
      if (pend.size() > 0 && pend[0] == cyc) begin
        adv_m = 1'b1;
        void'(pend.pop_front());
      end
      // A rising edge seen at this edge takes effect SYNC edges later.
      if (tick && !prev_t) pend.push_back(cyc + SYNC);
      prev_t = tick;
      exp_tick = 1'b0;
      if (set_en) begin
        ms = 0;
        if (inc_min) mm = (mm + 1) % 60;
        if (inc_hr)  mh = (mh + 1) % 24;
      end else if (adv_m) begin
        exp_tick = 1'b1;
        model_ticks++;
        ms++;
        if (ms == 60) begin
          ms = 0;
          mm++;
          if (mm == 60) begin
            mm = 0;
            mh = (mh + 1) % 24;
          end
        end
      end
    end
  end

  // Every-cycle compare of both instances against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("time24",  int'(a24), bcd6(mh, mm, ms));
      chk("flags24", int'({bus24.pm, bus24.sec_tick}), int'({1'b0, exp_tick}));
      chk("time12",  int'(a12), bcd6(h12_of(mh), mm, ms));
      chk("flags12", int'({bus12.pm, bus12.sec_tick}), int'({(mh >= 12), exp_tick}));
      if (bus24.sec_tick) dut_ticks++;
    end
  end

  task automatic tick_edge(input int hi = 2, input int lo = 3);
    @(negedge clk) tick = 1'b1;
    repeat (hi) @(negedge clk);
    tick = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic pulse_hr();
    @(negedge clk) inc_hr = 1'b1;
    @(negedge clk) inc_hr = 1'b0;
  endtask

  task automatic pulse_min();
    @(negedge clk) inc_min = 1'b1;
    @(negedge clk) inc_min = 1'b0;
  endtask

  task automatic set_mode(input logic v);
    @(negedge clk) set_en = v;
  endtask

  int t0;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_time24", int'(a24), 'h000000);
    chk("rst_time12", int'(a12), 'h120000);
    chk("rst_flags",  int'({bus24.pm, bus24.sec_tick, bus12.pm, bus12.sec_tick}), 0);
    @(negedge clk) rst = 1'b0;

    // 61 ticks from reset
    repeat (61) tick_edge();
    repeat (2) @(negedge clk);
    chk("t61_time24", int'(a24), 'h000101);
    chk("t61_time12", int'(a12), 'h120101);
    chk("t61_model",  bcd6(mh, mm, ms), 'h000101);
    chk("t61_ticks",  dut_ticks, 61);

    // Preload 23:59:58, then roll over midnight
    set_mode(1'b1);
    repeat (23) pulse_hr();
    repeat (58) pulse_min();
    set_mode(1'b0);
    repeat (58) tick_edge();
    chk("pre_235958", int'(a24), 'h235958);
    tick_edge();
    chk("pre_235959", int'(a24), 'h235959);
    chk("pre_115959_12h", int'(a12), 'h115959);
    chk("pre_pm_12h", int'(bus12.pm), 1);
    tick_edge();
    chk("roll_000000", int'(a24), 'h000000);
    chk("roll_120000_12h", int'(a12), 'h120000);
    chk("roll_pm_12h", int'(bus12.pm), 0);

    // 12-hour: 11:59:50 -> 12:00:00 pm, then 12 -> 01
    set_mode(1'b1);
    repeat (11) pulse_hr();
    repeat (59) pulse_min();
    set_mode(1'b0);
    repeat (50) tick_edge();
    chk("h12_115950", int'(a12), 'h115950);
    chk("h12_pm_before", int'(bus12.pm), 0);
    repeat (10) tick_edge();
    chk("h12_noon", int'(a12), 'h120000);
    chk("h12_pm_after", int'(bus12.pm), 1);
    chk("h24_noon", int'(a24), 'h120000);
    set_mode(1'b1);
    pulse_hr();
    chk("h12_one", int'(a12), 'h010000);
    chk("h12_pm_kept", int'(bus12.pm), 1);
    chk("h24_13", int'(a24), 'h130000);

    // Set mode at 10:20:35
    repeat (21) pulse_hr();
    repeat (20) pulse_min();
    set_mode(1'b0);
    repeat (35) tick_edge();
    chk("set_102035", int'(a24), 'h102035);
    set_mode(1'b1);
    @(negedge clk);
    chk("set_sec_clear", int'(a24), 'h102000);
    repeat (45) pulse_min();
    chk("set_min_wrap", int'(a24), 'h100500);
    @(negedge clk) begin inc_hr = 1'b1; inc_min = 1'b1; end
    @(negedge clk) begin inc_hr = 1'b0; inc_min = 1'b0; end
    chk("set_both", int'(a24), 'h110600);
    t0 = dut_ticks;
    repeat (3) tick_edge();
    chk("set_tick_ignored", int'(a24), 'h110600);
    chk("set_no_sec_tick", dut_ticks - t0, 0);

    // Long-held tick gives one advance; inc_hr outside set mode ignored
    set_mode(1'b0);
    @(negedge clk) tick = 1'b1;
    repeat (50) @(negedge clk);
    tick = 1'b0;
    repeat (4) @(negedge clk);
    chk("held_tick", int'(a24), 'h110601);
    pulse_hr();
    pulse_min();
    repeat (2) @(negedge clk);
    chk("inc_ignored", int'(a24), 'h110601);

    // Asynchronous reset mid-count
    repeat (5) tick_edge();
    chk("pre_rst", int'(a24), 'h110606);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_time24", int'(a24), 'h000000);
    chk("arst_time12", int'(a12), 'h120000);
    chk("arst_flags", int'({bus12.pm, bus24.sec_tick}), 0);
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_rst_idle", int'(a24), 'h000000);
    tick_edge();
    chk("post_rst_tick", int'(a24), 'h000001);

    // Randomised phase against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) tick = ~tick;
      inc_hr  = ($urandom_range(0, 5) == 0);
      inc_min = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 59) == 0) set_en = ~set_en;
    end
    @(negedge clk) begin
      tick = 1'b0; inc_hr = 1'b0; inc_min = 1'b0; set_en = 1'b0;
    end
    repeat (5) @(negedge clk);
    chk("tick_total", dut_ticks, model_ticks);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
